// File: rtl/bit_deser_pkg.sv
// rtl/bit_deser_pkg.sv - shared defaults and counter sizing for the bit deserializer
package bit_deser_pkg;

    localparam int WIDTH_DEFAULT     = 8;
    localparam bit MSB_FIRST_DEFAULT = 1'b1;

    // Counter must still be at least one bit wide for the smallest legal word.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int BIT_CNT_W = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/bit_deser_shift.sv
// rtl/bit_deser_shift.sv - assembly shift register and bit counter
module bit_deser_shift
    import bit_deser_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = MSB_FIRST_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_en,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] bit_cnt;

    always_comb begin
        shift_next = shift_q;
        if (MSB_FIRST) begin
            shift_next = {shift_q[WIDTH-2:0], in_bit};
        end else begin
            shift_next = {in_bit, shift_q[WIDTH-1:1]};
        end
    end

    // The word is handed out combinationally so the top can capture it on the
    // same edge that samples the last bit.
    assign word      = shift_next;
    assign word_done = in_en && (bit_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (in_en) begin
            shift_q <= shift_next;
            bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bit_deser.sv
// rtl/bit_deser.sv - serial-to-parallel deserializer with output handshake and sticky overrun
module bit_deser
    import bit_deser_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = MSB_FIRST_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_ovr
);

    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             xfer;
    logic             drop;

    bit_deser_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .in_en     (in_en),
        .word      (word),
        .word_done (word_done)
    );

    assign xfer = out_valid && out_ready;
    assign drop = word_done && out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (word_done && !drop) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
            // A drop on the same edge as clr_ovr leaves the flag set.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_deser.sv
// tb/tb_bit_deser.sv - scoreboard bench for bit_deser in both bit orders
module tb_bit_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_en = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_ovr = 1'b0;
    logic [7:0] out_data_m, out_data_l;
    logic       out_valid_m, out_valid_l;
    logic       overrun_m, overrun_l;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];

    always #5 clk = ~clk;

    bit_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_en(in_en),
        .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .overrun(overrun_m), .clr_ovr(clr_ovr)
    );

    bit_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_en(in_en),
        .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .overrun(overrun_l), .clr_ovr(clr_ovr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Scoreboard monitor: a transfer happens on the next edge whenever valid&ready.
    always @(negedge clk) begin
        if (!rst && out_valid_m && out_ready) begin
            if (exp_m.size() == 0) chk("msb_unexpected_word", {24'h0, out_data_m}, 32'hFFFF_FFFF);
            else chk("msb_xfer_data", {24'h0, out_data_m}, {24'h0, exp_m.pop_front()});
        end
        if (!rst && out_valid_l && out_ready) begin
            if (exp_l.size() == 0) chk("lsb_unexpected_word", {24'h0, out_data_l}, 32'hFFFF_FFFF);
            else chk("lsb_xfer_data", {24'h0, out_data_l}, {24'h0, exp_l.pop_front()});
        end
    end

    task automatic expect_word(input logic [7:0] w);
        exp_m.push_back(w);
        exp_l.push_back(rev8(w));
    endtask

    task automatic drive_bit(input logic b);
        in_bit = b;
        in_en  = 1'b1;
        @(posedge clk);
        #1;
        in_en  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) drive_bit(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_bit = ~in_bit;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] w;
        // Reset with in_en toggling
        rst = 1'b1;
        in_bit = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_en = (i == 0);
            @(posedge clk);
            #1;
        end
        in_en = 1'b0;
        chk("rst_valid", {31'h0, out_valid_m}, 32'h0);
        chk("rst_data", {24'h0, out_data_m}, 32'h0);
        chk("rst_ovr", {31'h0, overrun_m}, 32'h0);
        chk("rst_valid_lsb", {31'h0, out_valid_l}, 32'h0);
        rst = 1'b0;

        // Bit order, consecutive edges, ready high
        out_ready = 1'b1;
        expect_word(8'hD0);
        send_word(8'hD0);
        chk("order_valid", {31'h0, out_valid_m}, 32'h1);
        chk("order_msb_data", {24'h0, out_data_m}, 32'hD0);
        chk("order_lsb_data", {24'h0, out_data_l}, 32'h0B);
        @(posedge clk);
        #1;
        chk("order_valid_clr", {31'h0, out_valid_m}, 32'h0);

        // Backpressure: second word dropped, overrun set even with clr_ovr on that edge
        out_ready = 1'b0;
        expect_word(8'hD0);
        send_word(8'hD0);
        chk("bp_first_ovr", {31'h0, overrun_m}, 32'h0);
        w = 8'hFF;
        for (int i = 7; i >= 1; i--) drive_bit(w[i]);
        clr_ovr = 1'b1;
        drive_bit(w[0]);
        clr_ovr = 1'b0;
        chk("bp_data_held", {24'h0, out_data_m}, 32'hD0);
        chk("bp_valid_held", {31'h0, out_valid_m}, 32'h1);
        chk("bp_ovr_set_wins", {31'h0, overrun_m}, 32'h1);
        chk("bp_ovr_lsb", {31'h0, overrun_l}, 32'h1);
        clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        clr_ovr = 1'b0;
        chk("bp_ovr_cleared", {31'h0, overrun_m}, 32'h0);
        chk("bp_data_stable", {24'h0, out_data_m}, 32'hD0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_valid_clr", {31'h0, out_valid_m}, 32'h0);

        // Completion and transfer on the same edge
        expect_word(8'h3C);
        send_word(8'h3C);
        expect_word(8'h5A);
        w = 8'h5A;
        for (int i = 7; i >= 1; i--) drive_bit(w[i]);
        out_ready = 1'b1;
        drive_bit(w[0]);
        chk("simul_valid", {31'h0, out_valid_m}, 32'h1);
        chk("simul_data", {24'h0, out_data_m}, 32'h5A);
        chk("simul_ovr", {31'h0, overrun_m}, 32'h0);
        @(posedge clk);
        #1;
        chk("simul_valid_clr", {31'h0, out_valid_m}, 32'h0);

        // Gap of 5 idle cycles between bits 3 and 4
        w = 8'h96;
        expect_word(w);
        for (int i = 7; i >= 4; i--) drive_bit(w[i]);
        idle(5);
        chk("gap_no_valid", {31'h0, out_valid_m}, 32'h0);
        for (int i = 3; i >= 0; i--) drive_bit(w[i]);
        chk("gap_msb_data", {24'h0, out_data_m}, 32'h96);
        chk("gap_lsb_data", {24'h0, out_data_l}, 32'h69);
        @(posedge clk);
        #1;

        // Mid-word reset discards partial bits
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_valid", {31'h0, out_valid_m}, 32'h0);
        chk("midrst_data", {24'h0, out_data_m}, 32'h0);
        expect_word(8'hA5);
        send_word(8'hA5);
        chk("midrst_new_valid", {31'h0, out_valid_m}, 32'h1);
        chk("midrst_new_data", {24'h0, out_data_m}, 32'hA5);
        chk("midrst_new_lsb", {24'h0, out_data_l}, 32'hA5);
        idle(3);

        chk("sb_msb_drained", exp_m.size(), 32'h0);
        chk("sb_lsb_drained", exp_l.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
